// File: rtl/a5200_keypad_encoder_if.sv
// Keypad encoder bus: raw joystick word and halt in, POKEY keypad scan result out.
// master = producer of the joystick word (emu mapping), slave = the encoder.
interface a5200_keypad_encoder_if;
    logic [20:0] JOY;
    logic        HALT;
    logic [3:0]  KBCODE;
    logic        KEY_HELD;
    logic        KEY_STB;

    modport master (
        output JOY,
        output HALT,
        input  KBCODE,
        input  KEY_HELD,
        input  KEY_STB
    );

    modport slave (
        input  JOY,
        input  HALT,
        output KBCODE,
        output KEY_HELD,
        output KEY_STB
    );
endinterface

// File: rtl/a5200_keypad_encoder.sv
// Atari 5200 keypad encoder: debounces the 15 keypad buttons of one controller
// and reports a single accepted key (lowest code wins) as a POKEY scan result.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat strobes while a key is held.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no key accepted; next evaluation accepts the lowest pressed key
// ST_HELD | KBCODE latched and held; only its release is watched
module a5200_keypad_encoder #(
    parameter int TICK_DIV     = 56750,
    parameter int DEB_SAMPLES  = 3,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    a5200_keypad_encoder_if.slave   kp
);

    localparam int NKEYS  = 15;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    logic [TICK_W-1:0]      tick_cnt;
    logic                   tick;
    logic [NKEYS-1:0]       key_raw;
    logic [DEB_SAMPLES-1:0] hist     [NKEYS];
    logic [DEB_SAMPLES-1:0] hist_nxt [NKEYS];
    logic [NKEYS-1:0]       deb_q;
    logic [NKEYS-1:0]       deb_nxt;
    logic                   any_pressed;
    logic [3:0]             low_code;
    logic [0:0]             state;
    logic [3:0]             code_q;
    logic                   stb_q;
    logic                   accept;
    logic                   rep_fire;
    logic                   unused_joy;

    // Index = key code: digits 0..9, then *, #, Start, Pause, Reset.
    assign key_raw = {kp.JOY[10:6], kp.JOY[20:11]};

    // Low joystick bits are directions and fire buttons, not keypad keys.
    assign unused_joy = ^kp.JOY[5:0];

    // Sample tick is suppressed while halted so everything downstream freezes.
    assign tick = ~kp.HALT && (tick_cnt == TICK_LAST);

    // Free-running sample-tick counter, frozen by HALT.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_cnt <= '0;
        end else if (!kp.HALT) begin
            if (tick_cnt == TICK_LAST) tick_cnt <= '0;
            else                       tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Next history and debounced state; the FSM looks at these on the tick itself
    // so its registered outputs appear one cycle after the deciding tick.
    always_comb begin
        for (int k = 0; k < NKEYS; k++) begin
            hist_nxt[k] = {hist[k][DEB_SAMPLES-2:0], key_raw[k]};
            deb_nxt[k]  = deb_q[k];
            if (&hist_nxt[k])       deb_nxt[k] = 1'b1;
            else if (~|hist_nxt[k]) deb_nxt[k] = 1'b0;
        end
    end

    // Per-key sample history and debounced state, advanced once per tick.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NKEYS; k++) hist[k] <= '0;
            deb_q <= '0;
        end else if (tick) begin
            for (int k = 0; k < NKEYS; k++) hist[k] <= hist_nxt[k];
            deb_q <= deb_nxt;
        end
    end

    // Lowest-code pressed key; scanning downward leaves the smallest index last.
    always_comb begin
        any_pressed = 1'b0;
        low_code    = 4'h0;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (deb_nxt[k]) begin
                any_pressed = 1'b1;
                low_code    = 4'(k);
            end
        end
    end

    assign accept = tick && (state == ST_IDLE) && any_pressed;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;

    assign rep_fire = tick && (state == ST_HELD) && deb_nxt[code_q]
                      && (rep_cnt == REP_W'(1));

    // Repeat down-counter in ticks: loaded with the initial delay on accept,
    // reloaded with the rate at each terminal count, cleared when the key goes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rep_cnt <= '0;
        end else if (tick) begin
            if (accept) begin
                rep_cnt <= REP_W'(REPEAT_DELAY);
            end else if (state == ST_HELD) begin
                if (!deb_nxt[code_q])            rep_cnt <= '0;
                else if (rep_cnt == REP_W'(1))   rep_cnt <= REP_W'(REPEAT_RATE);
                else if (rep_cnt != '0)          rep_cnt <= rep_cnt - 1'b1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Accept/release FSM with registered code and one-cycle strobe.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            code_q <= 4'h0;
            stb_q  <= 1'b0;
        end else begin
            stb_q <= accept || rep_fire;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (any_pressed) begin
                            state  <= ST_HELD;
                            code_q <= low_code;
                        end
                    end
                    ST_HELD: begin
                        if (!deb_nxt[code_q]) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign kp.KBCODE   = code_q;
    assign kp.KEY_HELD = (state == ST_HELD);
    assign kp.KEY_STB  = stb_q;

endmodule

// File: tb/tb_a5200_keypad_encoder.sv
// Self-checking bench for a5200_keypad_encoder: directed test-plan steps plus a
// randomized phase, all checked every cycle against a tick-level reference model.
module tb_a5200_keypad_encoder;

    localparam int TD = 4;
    localparam int DS = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    a5200_keypad_encoder_if kp_if ();

    a5200_keypad_encoder #(
        .TICK_DIV     (TD),
        .DEB_SAMPLES  (DS),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .kp      (kp_if.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_seen = 0;

    // Reference model: per key, the value and length of the current run of equal
    // samples; a run of DS or more decides the debounced state.
    int m_tcnt;
    bit m_run_val [15];
    int m_run_len [15];
    bit m_deb     [15];
    bit m_held;
    int m_code;
    bit m_stb;
    int m_since;
    int m_stb_total;

    function automatic int joy_bit(int k);
        return (k < 10) ? (11 + k) : (k - 4);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tcnt = 0;
        for (int k = 0; k < 15; k++) begin
            m_run_val[k] = 1'b0;
            m_run_len[k] = DS;
            m_deb[k]     = 1'b0;
        end
        m_held  = 1'b0;
        m_code  = 0;
        m_stb   = 1'b0;
        m_since = 0;
    endtask

    task automatic model_step();
        bit tk;
        bit b;
        int pick;
        m_stb = 1'b0;
        if (kp_if.HALT) return;
        tk = (m_tcnt == TD - 1);
        m_tcnt = tk ? 0 : m_tcnt + 1;
        if (!tk) return;
        for (int k = 0; k < 15; k++) begin
            b = kp_if.JOY[joy_bit(k)];
            if (b == m_run_val[k]) m_run_len[k]++;
            else begin
                m_run_val[k] = b;
                m_run_len[k] = 1;
            end
            if (m_run_len[k] >= DS) m_deb[k] = m_run_val[k];
        end
        if (!m_held) begin
            pick = -1;
            for (int k = 14; k >= 0; k--) if (m_deb[k]) pick = k;
            if (pick >= 0) begin
                m_held  = 1'b1;
                m_code  = pick;
                m_stb   = 1'b1;
                m_since = 0;
            end
        end else if (!m_deb[m_code]) begin
            m_held = 1'b0;
        end else begin
            m_since++;
`ifdef KEYPAD_REPEAT_EN
            if (m_since == RD || (m_since > RD && ((m_since - RD) % RR) == 0)) m_stb = 1'b1;
`endif
        end
        if (m_stb) m_stb_total++;
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (RESET_N) model_step();
        #1;
        if (kp_if.KEY_STB === 1'b1) stb_seen++;
        check("kbcode",   32'(kp_if.KBCODE),   32'(m_code));
        check("key_held", 32'(kp_if.KEY_HELD), 32'(m_held));
        check("key_stb",  32'(kp_if.KEY_STB),  32'(m_stb));
    endtask

    task automatic run_cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_ticks(int n);
        run_cycles(n * TD);
    endtask

    task automatic reset_pulse();
        #2;
        RESET_N = 1'b0;
        #1;
        check("rst_kbcode",   32'(kp_if.KBCODE),   32'h0);
        check("rst_key_held", 32'(kp_if.KEY_HELD), 32'h0);
        check("rst_key_stb",  32'(kp_if.KEY_STB),  32'h0);
        model_reset();
        run_cycles(2);
        RESET_N = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        logic [20:0] joy;

        kp_if.JOY  = '0;
        kp_if.HALT = 1'b0;
        m_stb_total = 0;
        model_reset();
        #12;
        check("reset_kbcode",   32'(kp_if.KBCODE),   32'h0);
        check("reset_key_held", 32'(kp_if.KEY_HELD), 32'h0);
        check("reset_key_stb",  32'(kp_if.KEY_STB),  32'h0);
        RESET_N = 1'b1;

        // 1: single press of digit 4
        stb_seen = 0;
        kp_if.JOY[15] = 1'b1;
        run_ticks(2);
        run_cycles(TD - 1);
        check("t1_no_early_stb", 32'(stb_seen), 32'd0);
        run_cycles(1);
        check("t1_stb_after_3rd_tick", 32'(kp_if.KEY_STB), 32'd1);
        check("t1_kbcode", 32'(kp_if.KBCODE), 32'h4);
        run_ticks(2);
        kp_if.JOY = '0;
        run_cycles(3 * TD - 1);
        check("t1_held_before_release", 32'(kp_if.KEY_HELD), 32'd1);
        run_cycles(1);
        check("t1_held_dropped", 32'(kp_if.KEY_HELD), 32'd0);
        check("t1_one_strobe", 32'(stb_seen), 32'd1);
        run_ticks(2);

        // 2: bouncing Start never accepted
        stb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            kp_if.JOY[8] = (i % 2 == 0);
            run_ticks(1);
        end
        kp_if.JOY = '0;
        run_ticks(3);
        check("t2_no_strobe", 32'(stb_seen), 32'd0);
        check("t2_not_held", 32'(kp_if.KEY_HELD), 32'd0);

        // 3: priority and lockout
        stb_seen = 0;
        kp_if.JOY[6]  = 1'b1;
        kp_if.JOY[20] = 1'b1;
        run_ticks(3);
        check("t3_kbcode_9", 32'(kp_if.KBCODE), 32'h9);
        check("t3_one_strobe", 32'(stb_seen), 32'd1);
        kp_if.JOY[12] = 1'b1;
        run_ticks(4);
        check("t3_lockout", 32'(stb_seen), 32'd1);
        kp_if.JOY[20] = 1'b0;
        run_ticks(3);
        check("t3_released_9", 32'(kp_if.KEY_HELD), 32'd0);
        check("t3_no_strobe_on_release", 32'(stb_seen), 32'd1);
        run_ticks(1);
        check("t3_kbcode_1", 32'(kp_if.KBCODE), 32'h1);
        check("t3_second_strobe", 32'(stb_seen), 32'd2);
        kp_if.JOY = '0;
        run_ticks(4);

        // 4: HALT freezes debounce of #
        stb_seen = 0;
        kp_if.HALT = 1'b1;
        kp_if.JOY[7] = 1'b1;
        run_ticks(10);
        check("t4_halt_no_strobe", 32'(stb_seen), 32'd0);
        check("t4_halt_not_held", 32'(kp_if.KEY_HELD), 32'd0);
        kp_if.HALT = 1'b0;
        waited = 0;
        while (stb_seen == 0 && waited < 10 * TD) begin
            cycle();
            waited++;
        end
        check("t4_strobe_latency_cycles", 32'(waited), 32'(3 * TD));
        check("t4_kbcode_b", 32'(kp_if.KBCODE), 32'hB);
        kp_if.JOY = '0;
        run_ticks(4);

        // 5: async reset while Reset key is held
        kp_if.JOY[10] = 1'b1;
        run_ticks(3);
        check("t5_kbcode_e", 32'(kp_if.KBCODE), 32'hE);
        run_cycles(1);
        reset_pulse();
        stb_seen = 0;
        run_ticks(2);
        check("t5_no_early_reaccept", 32'(stb_seen), 32'd0);
        run_ticks(1);
        check("t5_reaccept", 32'(stb_seen), 32'd1);
        check("t5_reaccept_kbcode", 32'(kp_if.KBCODE), 32'hE);
        kp_if.JOY = '0;
        run_ticks(4);

        // 6: long hold of Pause
        stb_seen = 0;
        m_stb_total = 0;
        kp_if.JOY[9] = 1'b1;
        run_ticks(12);
        kp_if.JOY = '0;
        run_ticks(4);
        check("t6_strobe_count_model", 32'(stb_seen), 32'(m_stb_total));
`ifndef KEYPAD_REPEAT_EN
        check("t6_single_strobe", 32'(stb_seen), 32'd1);
`endif

        // Randomized phase: random key sets, ignored low bits, halts, odd phases
        for (int seg = 0; seg < 80; seg++) begin
            joy = 21'($urandom) & 21'h3F;
            for (int k = 0; k < 15; k++)
                if ($urandom_range(0, 4) == 0) joy[joy_bit(k)] = 1'b1;
            kp_if.JOY  = joy;
            kp_if.HALT = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) reset_pulse();
            run_cycles($urandom_range(1, 24));
        end
        kp_if.HALT = 1'b0;
        kp_if.JOY  = '0;
        run_ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
